// File: rtl/box_filter_scheduler.sv
// Round-robin shared moving-average filter: NUM_CH streams, each with its own
// FILTER_SIZE-deep history and running sum, producing one tagged average per accepted sample.
module box_filter_scheduler #(
  parameter int NUM_CH      = 4,
  parameter int FILTER_SIZE = 4,
  parameter int DATA_WIDTH  = 32,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int PTR_W  = (FILTER_SIZE > 1) ? $clog2(FILTER_SIZE) : 1,
  localparam int LOG_FS = $clog2(FILTER_SIZE),
  localparam int SUM_W  = DATA_WIDTH + LOG_FS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            req_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] req_data,
  output logic [NUM_CH-1:0]            req_ready,
  input  logic                         flush,
  output logic                         out_valid,
  output logic [CH_W-1:0]              out_ch,
  output logic [DATA_WIDTH-1:0]        out_data,
  input  logic                         out_ready
);

  logic [DATA_WIDTH-1:0] hist_q [NUM_CH][FILTER_SIZE];
  logic [SUM_W-1:0]      sum_q  [NUM_CH];
  logic [PTR_W-1:0]      ptr_q  [NUM_CH];
  logic [CH_W-1:0]       rr_q;
  logic                  out_valid_q;
  logic [CH_W-1:0]       out_ch_q;
  logic [DATA_WIDTH-1:0] out_data_q;

  logic                  grant_found;
  logic [CH_W-1:0]       grant_idx;
  logic                  accept;
  logic [DATA_WIDTH-1:0] sample_d;
  logic [DATA_WIDTH-1:0] oldest_d;
  logic [SUM_W-1:0]      sum_d;
  logic [CH_W-1:0]       rr_d;

  // First requesting channel at or after rr, wrapping around.
  always_comb begin
    int idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!grant_found && req_valid[CH_W'(idx)]) begin
        grant_found = 1'b1;
        grant_idx   = CH_W'(idx);
      end
    end
  end

  always_comb begin
    accept    = (!out_valid_q || out_ready) && !flush && grant_found;
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
    sample_d  = req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
    oldest_d  = hist_q[grant_idx][ptr_q[grant_idx]];
    sum_d     = sum_q[grant_idx] - SUM_W'(oldest_d) + SUM_W'(sample_d);
    rr_d      = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int p = 0; p < FILTER_SIZE; p++) hist_q[c][p] <= '0;
        sum_q[c] <= '0;
        ptr_q[c] <= '0;
      end
      rr_q        <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
    end else if (flush) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int p = 0; p < FILTER_SIZE; p++) hist_q[c][p] <= '0;
        sum_q[c] <= '0;
        ptr_q[c] <= '0;
      end
      rr_q        <= '0;
      out_valid_q <= 1'b0;
    end else if (accept) begin
      hist_q[grant_idx][ptr_q[grant_idx]] <= sample_d;
      ptr_q[grant_idx] <= ptr_q[grant_idx] + PTR_W'(1);
      sum_q[grant_idx] <= sum_d;
      rr_q             <= rr_d;
      out_valid_q      <= 1'b1;
      out_ch_q         <= grant_idx;
      // Power-of-two window: the divide is the top DATA_WIDTH bits of the sum.
      out_data_q       <= sum_d[SUM_W-1 -: DATA_WIDTH];
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_box_filter_scheduler.sv
// Directed bench for box_filter_scheduler: vector table for single-channel windows
// plus hand sequences for round robin, backpressure, flush and async reset.
module tb_box_filter_scheduler;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic         flush;
  logic         out_valid;
  logic [1:0]   out_ch;
  logic [31:0]  out_data;
  logic         out_ready;

  int checks = 0;
  int errors = 0;

  box_filter_scheduler #(.NUM_CH(4), .FILTER_SIZE(4), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .flush(flush), .out_valid(out_valid),
    .out_ch(out_ch), .out_data(out_data), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ch;
    logic [31:0] data;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Inputs are set just after a posedge; req_ready is sampled on the negedge,
  // outputs 1 time unit after the following posedge.
  task automatic cycle_check(input string name, input logic [3:0] exp_ready,
                             input logic exp_v, input logic [1:0] exp_ch,
                             input logic [31:0] exp_d);
    @(negedge clk);
    chk({name, " req_ready"}, 64'(req_ready), 64'(exp_ready));
    @(posedge clk);
    #1;
    chk({name, " out_valid"}, 64'(out_valid), 64'(exp_v));
    if (exp_v) begin
      chk({name, " out_ch"}, 64'(out_ch), 64'(exp_ch));
      chk({name, " out_data"}, 64'(out_data), 64'(exp_d));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; flush = 1'b0; out_ready = 1'b1;
    vecs[0] = '{0, 32'd4,  32'd1};
    vecs[1] = '{0, 32'd8,  32'd3};
    vecs[2] = '{0, 32'd12, 32'd6};
    vecs[3] = '{0, 32'd16, 32'd10};
    vecs[4] = '{0, 32'd20, 32'd14};
    vecs[5] = '{1, 32'hFFFFFFFF, 32'h3FFFFFFF};
    vecs[6] = '{1, 32'hFFFFFFFF, 32'h7FFFFFFF};
    vecs[7] = '{1, 32'hFFFFFFFF, 32'hBFFFFFFF};
    vecs[8] = '{1, 32'hFFFFFFFF, 32'hFFFFFFFF};

    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset out_ch", 64'(out_ch), 64'd0);
    chk("reset out_data", 64'(out_data), 64'd0);
    @(negedge clk);
    chk("idle req_ready", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1;

    // Single-channel windows, back to back at full rate.
    for (int i = 0; i < 9; i++) begin
      req_valid = 4'(1 << vecs[i].ch);
      req_data  = '0;
      req_data[vecs[i].ch*32 +: 32] = vecs[i].data;
      cycle_check($sformatf("vec%0d", i), 4'(1 << vecs[i].ch), 1'b1,
                  2'(vecs[i].ch), vecs[i].exp_data);
    end

    // Flush with requests pending: no accept, output cleared, rr back to 0.
    req_valid = 4'hF;
    req_data  = '0;
    req_data[31:0] = 32'd8;
    flush = 1'b1;
    cycle_check("flush", 4'h0, 1'b0, 2'd0, 32'd0);
    flush = 1'b0;
    cycle_check("post-flush ch0", 4'h1, 1'b1, 2'd0, 32'd2);

    // Backpressure: hold result, refuse input for 5 cycles.
    out_ready = 1'b0;
    req_valid = 4'h8;
    req_data  = '0;
    req_data[127:96] = 32'd100;
    for (int i = 0; i < 5; i++)
      cycle_check($sformatf("stall%0d", i), 4'h0, 1'b1, 2'd0, 32'd2);
    out_ready = 1'b1;
    cycle_check("release ch3", 4'h8, 1'b1, 2'd3, 32'd25);

    // Drain with no new request: out_valid drops.
    req_valid = 4'h0;
    cycle_check("drain", 4'h0, 1'b0, 2'd0, 32'd0);

    // Re-create a pending output, then reset between edges.
    req_valid = 4'h4;
    req_data  = '0;
    req_data[95:64] = 32'd80;
    cycle_check("pre-rst ch2", 4'h4, 1'b1, 2'd2, 32'd20);
    req_valid = 4'h0;
    out_ready = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk("async rst out_valid", 64'(out_valid), 64'd0);
    chk("async rst out_data", 64'(out_data), 64'd0);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    req_valid = 4'h4;
    req_data[95:64] = 32'd40;
    cycle_check("post-rst ch2", 4'h4, 1'b1, 2'd2, 32'd10);

    // Round robin with all channels requesting continuously.
    do_reset();
    req_valid = 4'hF;
    for (int c = 0; c < 4; c++) req_data[c*32 +: 32] = 32'(4 * (c + 1));
    for (int k = 0; k < 8; k++) begin
      int c;
      c = k % 4;
      cycle_check($sformatf("rr%0d", k), 4'(1 << c), 1'b1, 2'(c),
                  32'((c + 1) * (k / 4 + 1)));
    end
    req_valid = 4'h0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/box_filter_scheduler.md
Name: box_filter_scheduler

Overview:
- Shares one moving-average (box filter) datapath among NUM_CH independent sample streams.
- Round-robin arbitration picks one stream per cycle. The block keeps a FILTER_SIZE-deep history and a running sum for each channel.
- Emits one averaged result per accepted sample, tagged with its channel id.
- Sits between the per-channel sample sources and the downstream consumer, using valid/ready handshakes on both sides.

Parameters:
- NUM_CH, 4, number of requesting channels (>=2).
- FILTER_SIZE, 4, window length per channel (>=2; power of two so the divide is a shift).
- DATA_WIDTH, 32, sample and result width.
- Derived (localparams):
  - CH_W = max(1, $clog2(NUM_CH))
  - PTR_W = max(1, $clog2(FILTER_SIZE))
  - SUM_W = DATA_WIDTH + $clog2(FILTER_SIZE)

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- req_valid  input  NUM_CH  per-channel sample valid
- req_data  input  NUM_CH*DATA_WIDTH  per-channel samples; channel i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  output  NUM_CH  one-hot (or zero) accept strobe
- flush  input  1  synchronous clear of all channel state
- out_valid  output  1  result valid
- out_ch  output  CH_W  channel id of result
- out_data  output  DATA_WIDTH  averaged result
- out_ready  input  1  downstream accept

Behaviour:
- Reset (asynchronous, rst=1) clears everything immediately:
  - out_valid=0, out_ch=0, out_data=0
  - all history entries=0, all sums=0, all write pointers=0
  - round-robin pointer rr=0
- Accept condition:
  - can_accept = (!out_valid || out_ready) && !flush
  - g = first channel with req_valid set, searching from rr upward and wrapping mod NUM_CH
  - req_ready[g]=1 iff can_accept and any req_valid; all other req_ready bits are 0.
  - req_ready is combinational from req_valid, out_valid, out_ready and flush. req_valid never depends on req_ready.
- On a transfer to channel g with sample d, at the next posedge:
  - hist[g][ptr[g]] <= d
  - ptr[g] <= (ptr[g]+1) % FILTER_SIZE
  - sum[g] <= sum[g] - hist[g][ptr[g]] + d, computed in SUM_W bits (cannot overflow)
  - out_data <= new_sum / FILTER_SIZE (floor, fits DATA_WIDTH exactly)
  - out_ch <= g, out_valid <= 1
  - rr <= (g+1) % NUM_CH
- Latency: one cycle from accept to out_valid.
- Output hold:
  - While out_valid && !out_ready, out_valid, out_ch and out_data stay stable and no input is accepted.
  - If out_valid && out_ready with no new accept, out_valid <= 0 at the next edge.
  - Accept and output drain in the same cycle give full throughput: 1 sample/cycle.
- Warm-up: history starts at zero, so the first FILTER_SIZE outputs of each channel average against zeros (partial windows are not special-cased).
- Channel isolation: channels never share history, sum or pointer state.
- Idle: with no req_valid set, rr holds and no state changes except output drain.
- flush (synchronous), at the next edge:
  - clears all history, sums, pointers and rr, and sets out_valid to 0
  - no accept occurs in a flush cycle
  - flush has priority over out_ready and req_valid
- Reset mid-operation: a pending output is dropped, with no partial update.

Test Plan:
1. NUM_CH=4, FILTER_SIZE=4, only ch0 valid with samples 4, 8, 12, 16, 20 (out_ready=1) -> outputs ch0: 1, 3, 6, 10, 14, one per cycle at 1-cycle latency.
2. All four channels valid continuously, out_ready=1 -> grant order 0,1,2,3,0,1...; each channel's req_ready is high exactly one cycle in four; each output's out_ch matches its grant.
3. Backpressure: out_valid=1 and out_ready held 0 for 5 cycles -> req_ready=0, out_data/out_ch stable. Raise out_ready -> an accept happens in that same cycle and the new result appears next cycle.
4. ch1 pushes 0xFFFFFFFF four times -> 0x3FFFFFFF, 0x7FFFFFFF, 0xBFFFFFFF, 0xFFFFFFFF (no wrap in the sum).
5. ch0 history {4,8,12,16}, pulse flush, then push 8 on ch0 -> out_valid low the cycle after flush, next result ch0=2; rr restarts at 0.
6. Assert rst asynchronously between clock edges with out_valid=1 -> out_valid falls immediately. After release, ch2 push 40 -> out_data=10, proving history and sum were cleared.
